// File: rtl/z80_bus_serializer.sv
// Serialises the Z80 address/control bus onto a narrow pin group, one slice per enabled clock.
// MANUAL picks a live slice; AUTO streams coherent frames; ON_CHANGE streams a frame when the bus moves.
module z80_bus_serializer #(
  parameter int ADDR_W = 16,
  parameter int CTRL_W = 8,
  parameter int PIN_W  = 8,
  localparam int A_SL  = (ADDR_W + PIN_W - 1) / PIN_W,
  localparam int C_SL  = (CTRL_W + PIN_W - 1) / PIN_W,
  localparam int NSL   = A_SL + C_SL,
  localparam int SEL_W = (NSL > 1) ? $clog2(NSL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cen,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [PIN_W-1:0]  pins_out,
  output logic [SEL_W-1:0]  slice_idx,
  output logic              frame_start,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    MODE_MANUAL    = 2'b00,
    MODE_AUTO      = 2'b01,
    MODE_ON_CHANGE = 2'b10
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NSL - 1);

  // Slices past the end of the map (index >= NSL) fall through to zero.
  function automatic logic [PIN_W-1:0] slice_of(input logic [SEL_W-1:0]  k,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [CTRL_W-1:0] c);
    logic [NSL*PIN_W-1:0] v;
    logic [PIN_W-1:0]     r;
    v = '0;
    v[ADDR_W-1:0] = a;
    v[A_SL*PIN_W +: CTRL_W] = c;
    r = '0;
    for (int i = 0; i < NSL; i++) begin
      if (k == SEL_W'(i)) r = v[i*PIN_W +: PIN_W];
    end
    return r;
  endfunction

  logic [PIN_W-1:0]  pins_q, pins_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] snap_addr_q, snap_addr_d;
  logic [CTRL_W-1:0] snap_ctrl_q, snap_ctrl_d;
  mode_e             mode_q, mode_d;

  mode_e             mode_eff;
  logic [SEL_W-1:0]  cnt_cur;
  state_e            state_cur;
  logic              bus_diff;

  always_comb begin
    mode_eff    = (mode == 2'b10) ? MODE_ON_CHANGE :
                  (mode == 2'b00) ? MODE_MANUAL : MODE_AUTO;
    // The first enabled edge in a new mode starts that mode's sequencing from scratch.
    cnt_cur     = (mode_eff != mode_q) ? '0 : cnt_q;
    state_cur   = (mode_eff != mode_q) ? ST_IDLE : state_q;
    bus_diff    = (addr != snap_addr_q) || (ctrl != snap_ctrl_q);

    pins_d      = pins_q;
    idx_d       = idx_q;
    fs_d        = 1'b0;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    snap_addr_d = snap_addr_q;
    snap_ctrl_d = snap_ctrl_q;
    mode_d      = mode_q;

    if (cen) begin
      mode_d  = mode_eff;
      cnt_d   = '0;
      state_d = ST_IDLE;
      if (mode_eff != MODE_ON_CHANGE) overrun_d = 1'b0;
      case (mode_eff)
        MODE_MANUAL: begin
          pins_d = slice_of(sel, addr, ctrl);
          idx_d  = sel;
        end
        MODE_AUTO: begin
          if (cnt_cur == '0) begin
            snap_addr_d = addr;
            snap_ctrl_d = ctrl;
            pins_d      = slice_of('0, addr, ctrl);
            idx_d       = '0;
            fs_d        = 1'b1;
          end else begin
            pins_d = slice_of(cnt_cur, snap_addr_q, snap_ctrl_q);
            idx_d  = cnt_cur;
          end
          cnt_d = (cnt_cur == LAST) ? '0 : cnt_cur + SEL_W'(1);
        end
        default: begin
          if (state_cur == ST_IDLE) begin
            if (bus_diff) begin
              snap_addr_d = addr;
              snap_ctrl_d = ctrl;
              pins_d      = slice_of('0, addr, ctrl);
              idx_d       = '0;
              fs_d        = 1'b1;
              if (NSL > 1) begin
                state_d = ST_SEND;
                cnt_d   = SEL_W'(1);
              end
            end
          end else begin
            pins_d = slice_of(cnt_cur, snap_addr_q, snap_ctrl_q);
            idx_d  = cnt_cur;
            if (bus_diff) overrun_d = 1'b1;
            if (cnt_cur != LAST) begin
              state_d = ST_SEND;
              cnt_d   = cnt_cur + SEL_W'(1);
            end
          end
        end
      endcase
    end
    busy_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pins_q      <= '0;
      idx_q       <= '0;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      snap_addr_q <= '0;
      snap_ctrl_q <= '1;
      mode_q      <= MODE_MANUAL;
    end else begin
      pins_q      <= pins_d;
      idx_q       <= idx_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      snap_addr_q <= snap_addr_d;
      snap_ctrl_q <= snap_ctrl_d;
      mode_q      <= mode_d;
    end
  end

  assign pins_out    = pins_q;
  assign slice_idx   = idx_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_z80_bus_serializer.sv
// Bench for z80_bus_serializer: default 16/8/8 instance plus a 12/4/8 instance for padding.
module tb_z80_bus_serializer;
  logic        clk = 1'b0;
  logic        reset, cen;
  logic [1:0]  mode, sel;
  logic [15:0] addr;
  logic [7:0]  ctrl;
  logic [7:0]  pins_out;
  logic [1:0]  slice_idx;
  logic        frame_start, busy, overrun;
  logic [11:0] addr_n;
  logic [3:0]  ctrl_n;
  logic [7:0]  pins_n;
  logic [1:0]  idx_n;
  logic        fs_n, busy_n, ovr_n;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  z80_bus_serializer dut (
    .clk(clk), .reset(reset), .cen(cen), .mode(mode), .sel(sel),
    .addr(addr), .ctrl(ctrl), .pins_out(pins_out), .slice_idx(slice_idx),
    .frame_start(frame_start), .busy(busy), .overrun(overrun)
  );

  z80_bus_serializer #(.ADDR_W(12), .CTRL_W(4), .PIN_W(8)) dut_n (
    .clk(clk), .reset(reset), .cen(cen), .mode(mode), .sel(sel),
    .addr(addr_n), .ctrl(ctrl_n), .pins_out(pins_n), .slice_idx(idx_n),
    .frame_start(fs_n), .busy(busy_n), .overrun(ovr_n)
  );

  // Reference slice map for the 16/8/8 layout: addr low, addr high, ctrl, then zero.
  function automatic logic [7:0] slice_ref(int k, logic [15:0] a, logic [7:0] c);
    case (k)
      0:       return a[7:0];
      1:       return a[15:8];
      2:       return c;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 2'b01; cen = 1'b1; sel = 2'd0; addr = 16'hBEEF; ctrl = 8'h5A; reset = 1'b1;
    addr_n = 12'hABC; ctrl_n = 4'h9;
    step(); step();
    tests++;
    if ({pins_out, slice_idx, frame_start, busy, overrun} !== {8'h00, 2'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_state got pins=%h idx=%0d fs=%b busy=%b ovr=%b exp 00/0/0/0/0",
               pins_out, slice_idx, frame_start, busy, overrun);
    end
    reset = 1'b0;
    step();
    tests++;
    if ({pins_out, slice_idx, frame_start} !== {8'hEF, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_release got pins=%h idx=%0d fs=%b exp ef/0/1", pins_out, slice_idx, frame_start);
    end
  endtask

  task automatic test_manual();
    logic [7:0] exp_tab [4] = '{8'hEF, 8'hBE, 8'h5A, 8'h00};
    logic [7:0] e;
    mode = 2'b00; addr = 16'hBEEF; ctrl = 8'h5A;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      tests++;
      if ({pins_out, slice_idx, frame_start} !== {exp_tab[s], 2'(s), 1'b0}) begin
        fails++;
        $display("FAIL manual_sel%0d got pins=%h idx=%0d fs=%b exp %h/%0d/0", s, pins_out, slice_idx, frame_start, exp_tab[s], s);
      end
    end
    for (int i = 0; i < 20; i++) begin
      sel  = 2'($urandom_range(0, 3));
      addr = 16'($urandom);
      ctrl = 8'($urandom);
      e = slice_ref(int'(sel), addr, ctrl);
      step();
      tests++;
      if ({pins_out, slice_idx, frame_start} !== {e, sel, 1'b0}) begin
        fails++;
        $display("FAIL manual_rand got pins=%h idx=%0d fs=%b exp %h/%0d/0", pins_out, slice_idx, frame_start, e, sel);
      end
    end
  endtask

  task automatic test_auto();
    logic [7:0]  exp_tab [6] = '{8'h34, 8'h12, 8'hFE, 8'h78, 8'h56, 8'hFE};
    logic [15:0] snap_a;
    logic [7:0]  snap_c, e_pins;
    logic [1:0]  e_idx;
    logic        e_fs;
    int          pos;
    mode = 2'b01; addr = 16'h1234; ctrl = 8'hFE;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) addr = 16'h5678;
      tests++;
      if ({pins_out, slice_idx, frame_start} !== {exp_tab[i], 2'(i % 3), (i % 3) == 0}) begin
        fails++;
        $display("FAIL auto_frame%0d got pins=%h idx=%0d fs=%b exp %h/%0d/%b", i, pins_out, slice_idx,
                 frame_start, exp_tab[i], i % 3, (i % 3) == 0);
      end
    end
    pos = 0; snap_a = 16'h5678; snap_c = 8'hFE; e_pins = 8'hFE; e_idx = 2'd2;
    mode = 2'b11;
    for (int i = 0; i < 40; i++) begin
      addr = 16'($urandom);
      ctrl = 8'($urandom);
      cen  = ($urandom_range(0, 3) != 0);
      e_fs = 1'b0;
      if (cen) begin
        if (pos == 0) begin
          snap_a = addr; snap_c = ctrl; e_fs = 1'b1;
        end
        e_pins = slice_ref(pos, snap_a, snap_c);
        e_idx  = 2'(pos);
        pos    = (pos + 1) % 3;
      end
      step();
      tests++;
      if ({pins_out, slice_idx, frame_start} !== {e_pins, e_idx, e_fs}) begin
        fails++;
        $display("FAIL auto_rand got pins=%h idx=%0d fs=%b exp %h/%0d/%b", pins_out, slice_idx, frame_start, e_pins, e_idx, e_fs);
      end
    end
    cen = 1'b1;
  endtask

  task automatic test_cen_hold();
    cen = 1'b1; mode = 2'b00; addr = 16'hC0DE; ctrl = 8'h3C;
    step();
    mode = 2'b01;
    step();
    tests++;
    if ({pins_out, slice_idx, frame_start} !== {8'hDE, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL mode_restart got pins=%h idx=%0d fs=%b exp de/0/1", pins_out, slice_idx, frame_start);
    end
    step();
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({pins_out, slice_idx, frame_start} !== {8'hC0, 2'd1, 1'b0}) begin
        fails++;
        $display("FAIL cen_hold%0d got pins=%h idx=%0d fs=%b exp c0/1/0", i, pins_out, slice_idx, frame_start);
      end
    end
    cen = 1'b1;
    step();
    tests++;
    if ({pins_out, slice_idx, frame_start} !== {8'h3C, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL cen_resume got pins=%h idx=%0d fs=%b exp 3c/2/0", pins_out, slice_idx, frame_start);
    end
  endtask

  task automatic test_on_change();
    // Expected {pins, idx, fs, busy, overrun} per edge; addr is changed before the edge listed.
    logic [15:0] a_tab [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001,
                               16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0003, 16'h0003};
    logic [12:0] e_tab [12] = '{{8'h00, 2'd0, 3'b000}, {8'h00, 2'd0, 3'b000}, {8'h00, 2'd0, 3'b000},
                               {8'h01, 2'd0, 3'b110}, {8'h00, 2'd1, 3'b010}, {8'hFF, 2'd2, 3'b000},
                               {8'hFF, 2'd2, 3'b000}, {8'h02, 2'd0, 3'b110}, {8'h00, 2'd1, 3'b011},
                               {8'hFF, 2'd2, 3'b001}, {8'h03, 2'd0, 3'b111}, {8'h00, 2'd1, 3'b011}};
    mode = 2'b10; addr = 16'h0000; ctrl = 8'hFF; cen = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      addr = a_tab[i];
      step();
      tests++;
      if ({pins_out, slice_idx, frame_start, busy, overrun} !== e_tab[i]) begin
        fails++;
        $display("FAIL onchg_edge%0d got pins=%h idx=%0d fs=%b busy=%b ovr=%b exp %h", i, pins_out,
                 slice_idx, frame_start, busy, overrun, e_tab[i]);
      end
    end
    mode = 2'b01;
    step();
    tests++;
    if ({pins_out, frame_start, busy, overrun} !== {8'h03, 3'b100}) begin
      fails++;
      $display("FAIL onchg_leave got pins=%h fs=%b busy=%b ovr=%b exp 03/1/0/0", pins_out, frame_start, busy, overrun);
    end
  endtask

  task automatic test_narrow();
    logic [7:0] exp_tab [4] = '{8'hBC, 8'h0A, 8'h09, 8'hBC};
    addr_n = 12'hABC; ctrl_n = 4'h9; mode = 2'b00; cen = 1'b1;
    step();
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({pins_n, idx_n, fs_n} !== {exp_tab[i], 2'(i % 3), (i % 3) == 0}) begin
        fails++;
        $display("FAIL narrow_slice%0d got pins=%h idx=%0d fs=%b exp %h/%0d/%b", i, pins_n, idx_n, fs_n,
                 exp_tab[i], i % 3, (i % 3) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_cen_hold();
    test_on_change();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
